// File: rtl/mips32_ram_arbiter_if.sv
// Bundles the core instruction/data memory ports and the block RAM port of the arbiter.
// slave = arbiter view; master = core + RAM view.
interface mips32_ram_arbiter_if #(
  parameter int unsigned AWIDTH = 10
);
  logic              InstMem_Read;
  logic [29:0]       InstMem_Address;
  logic [31:0]       InstMem_In;
  logic              InstMem_Ready;
  logic              DataMem_Read;
  logic [3:0]        DataMem_Write;
  logic [29:0]       DataMem_Address;
  logic [31:0]       DataMem_Out;
  logic [31:0]       DataMem_In;
  logic              DataMem_Ready;
  logic [AWIDTH-1:0] ramReadAddr;
  logic              ramReadEnable;
  logic [31:0]       ramReadData;
  logic [AWIDTH-1:0] ramWriteAddr;
  logic [31:0]       ramWriteData;
  logic [3:0]        ramWriteLane;
  logic              ramWriteEnable;

  modport slave (
    input  InstMem_Read, InstMem_Address,
    input  DataMem_Read, DataMem_Write, DataMem_Address, DataMem_Out,
    input  ramReadData,
    output InstMem_In, InstMem_Ready, DataMem_In, DataMem_Ready,
    output ramReadAddr, ramReadEnable,
    output ramWriteAddr, ramWriteData, ramWriteLane, ramWriteEnable
  );

  modport master (
    output InstMem_Read, InstMem_Address,
    output DataMem_Read, DataMem_Write, DataMem_Address, DataMem_Out,
    output ramReadData,
    input  InstMem_In, InstMem_Ready, DataMem_In, DataMem_Ready,
    input  ramReadAddr, ramReadEnable,
    input  ramWriteAddr, ramWriteData, ramWriteLane, ramWriteEnable
  );
endinterface

// File: rtl/mips32_ram_arbiter.sv
// Arbitrates MIPS32 instruction and data memory ports onto one block RAM with a
// registered read port; alternates grants under contention and pulses Ready per access.
module mips32_ram_arbiter #(
  parameter int unsigned AWIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  mips32_ram_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_INST = 2'd1,
    RD_DATA = 2'd2,
    WR_DONE = 2'd3
  } state_t;

  state_t state, nextState;
  logic   lastData, nextLastData;
  logic   instReq, dataReq, isStore, grantData, grantInst;
  logic   unusedAddrBits;

  assign unusedAddrBits = ^{bus.InstMem_Address[29:AWIDTH], bus.DataMem_Address[29:AWIDTH]};

  always_comb begin
    instReq   = bus.InstMem_Read;
    isStore   = |bus.DataMem_Write;
    dataReq   = bus.DataMem_Read | isStore;
    grantData = dataReq && (!instReq || !lastData);
    grantInst = instReq && !grantData;
  end

  // RAM enables only ever fire in IDLE, so a held request is not re-issued
  // during its Ready cycle; everything is held off while reset is asserted.
  always_comb begin
    nextState          = state;
    nextLastData       = lastData;
    bus.ramReadAddr    = '0;
    bus.ramReadEnable  = 1'b0;
    bus.ramWriteAddr   = '0;
    bus.ramWriteData   = '0;
    bus.ramWriteLane   = '0;
    bus.ramWriteEnable = 1'b0;
    case (state)
      IDLE: begin
        if (!reset) begin
          if (grantData) begin
            nextLastData = 1'b1;
            if (isStore) begin
              bus.ramWriteEnable = 1'b1;
              bus.ramWriteLane   = bus.DataMem_Write;
              bus.ramWriteAddr   = bus.DataMem_Address[AWIDTH-1:0];
              bus.ramWriteData   = bus.DataMem_Out;
              nextState          = WR_DONE;
            end else begin
              bus.ramReadEnable  = 1'b1;
              bus.ramReadAddr    = bus.DataMem_Address[AWIDTH-1:0];
              nextState          = RD_DATA;
            end
          end else if (grantInst) begin
            nextLastData       = 1'b0;
            bus.ramReadEnable  = 1'b1;
            bus.ramReadAddr    = bus.InstMem_Address[AWIDTH-1:0];
            nextState          = RD_INST;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    bus.InstMem_Ready = (state == RD_INST);
    bus.DataMem_Ready = (state == RD_DATA) || (state == WR_DONE);
    bus.InstMem_In    = (state == RD_INST) ? bus.ramReadData : '0;
    bus.DataMem_In    = (state == RD_DATA) ? bus.ramReadData : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      lastData <= 1'b0;
    end else begin
      state    <= nextState;
      lastData <= nextLastData;
    end
  end

endmodule

// File: tb/tb_mips32_ram_arbiter.sv
// Self-checking bench: behavioural block RAM, table of single accesses with a
// scoreboard for returned data, plus contention and reset-mid-access sequences.
module tb_mips32_ram_arbiter;
  localparam int unsigned AWIDTH = 10;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mips32_ram_arbiter_if #(.AWIDTH(AWIDTH)) bus ();

  mips32_ram_arbiter #(.AWIDTH(AWIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural RAM: registered read, byte-laned write, plus a bench preload port.
  logic [31:0]       mem [0:(1<<AWIDTH)-1];
  logic [31:0]       rdData;
  logic              tbWe = 1'b0;
  logic [AWIDTH-1:0] tbAddr = '0;
  logic [31:0]       tbData = '0;

  always @(posedge clock) begin
    if (tbWe) mem[tbAddr] <= tbData;
    if (bus.ramWriteEnable)
      for (int i = 0; i < 4; i++)
        if (bus.ramWriteLane[i]) mem[bus.ramWriteAddr][8*i +: 8] <= bus.ramWriteData[8*i +: 8];
    if (bus.ramReadEnable) rdData <= mem[bus.ramReadAddr];
  end
  assign bus.ramReadData = rdData;

  typedef struct {
    logic        isInst;
    logic        rd;
    logic [3:0]  lanes;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] expData;
  } vec_t;

  vec_t        vecs [14];
  logic [31:0] instQ [$];
  logic [31:0] dataQ [$];
  int          compared   = 0;
  int          mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic dropReq();
    bus.InstMem_Read    = 1'b0;
    bus.DataMem_Read    = 1'b0;
    bus.DataMem_Write   = 4'h0;
  endtask

  task automatic doAccess(input vec_t v);
    logic [31:0] expAddr;
    @(posedge clock); #1;
    expAddr = 32'(v.addr[AWIDTH-1:0]);
    if (v.isInst) begin
      bus.InstMem_Read    = 1'b1;
      bus.InstMem_Address = v.addr;
      instQ.push_back(v.expData);
    end else begin
      bus.DataMem_Read    = v.rd;
      bus.DataMem_Write   = v.lanes;
      bus.DataMem_Address = v.addr;
      bus.DataMem_Out     = v.wdata;
      dataQ.push_back(v.expData);
    end
    @(negedge clock);
    check("ready_in_grant", 32'({bus.InstMem_Ready, bus.DataMem_Ready}), 32'd0);
    if (v.lanes != 4'h0) begin
      check("wr_grant", 32'({bus.ramWriteEnable, bus.ramReadEnable, bus.ramWriteLane}),
            32'({1'b1, 1'b0, v.lanes}));
      check("wr_addr", 32'(bus.ramWriteAddr), expAddr);
      check("wr_data", bus.ramWriteData, v.wdata);
    end else begin
      check("rd_grant", 32'({bus.ramReadEnable, bus.ramWriteEnable}), 32'b10);
      check("rd_addr", 32'(bus.ramReadAddr), expAddr);
    end
    @(posedge clock); #1;
    @(negedge clock);
    check("ready", 32'({bus.InstMem_Ready, bus.DataMem_Ready}), v.isInst ? 32'b10 : 32'b01);
    check("no_reissue", 32'({bus.ramReadEnable, bus.ramWriteEnable}), 32'd0);
    @(posedge clock); #1;
    dropReq();
    check("sb_drained", 32'(instQ.size() + dataQ.size()), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 4'hF, 30'd5,     32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 4'h0, 30'd5,     32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b0, 4'hF, 30'd7,     32'h11223344, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 4'h1, 30'd7,     32'h000000AA, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 4'h0, 30'd7,     32'h0,        32'h112233AA};
    vecs[5]  = '{1'b0, 1'b0, 4'hF, 30'd9,     32'hCAFEF00D, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 4'h0, 30'h409,   32'h0,        32'hCAFEF00D};
    vecs[7]  = '{1'b0, 1'b0, 4'hA, 30'd7,     32'h55667788, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 4'h0, 30'd7,     32'h0,        32'h552277AA};
    vecs[9]  = '{1'b1, 1'b0, 4'h0, 30'd2,     32'h0,        32'h24080001};
    vecs[10] = '{1'b0, 1'b1, 4'hF, 30'd12,    32'hA5A5A5A5, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 4'h0, 30'd12,    32'h0,        32'hA5A5A5A5};
    vecs[12] = '{1'b1, 1'b0, 4'h0, 30'h403,   32'h0,        32'h5};
    vecs[13] = '{1'b0, 1'b1, 4'h0, 30'd3,     32'h0,        32'h5};

    // Scoreboard monitor: pops an expectation for every Ready pulse.
    fork
      forever begin
        @(negedge clock);
        if (bus.InstMem_Ready) begin
          if (instQ.size() == 0) check("inst_unexpected_ready", 32'd1, 32'd0);
          else check("inst_data", bus.InstMem_In, instQ.pop_front());
        end
        if (bus.DataMem_Ready) begin
          if (dataQ.size() == 0) check("data_unexpected_ready", 32'd1, 32'd0);
          else check("data_data", bus.DataMem_In, dataQ.pop_front());
        end
      end
    join_none

    // Both ports request from reset; preload words 2 and 3 meanwhile.
    bus.InstMem_Read    = 1'b1;
    bus.InstMem_Address = 30'd2;
    bus.DataMem_Read    = 1'b1;
    bus.DataMem_Write   = 4'h0;
    bus.DataMem_Address = 30'd3;
    bus.DataMem_Out     = 32'h0;
    tbWe = 1'b1; tbAddr = 10'd2; tbData = 32'h24080001;
    @(posedge clock); #1;
    tbAddr = 10'd3; tbData = 32'h5;
    @(posedge clock); #1;
    tbWe = 1'b0;
    @(negedge clock);
    check("rst_ready", 32'({bus.InstMem_Ready, bus.DataMem_Ready}), 32'd0);
    check("rst_ram_en", 32'({bus.ramReadEnable, bus.ramWriteEnable, bus.ramWriteLane}), 32'd0);
    check("rst_inst_in", bus.InstMem_In, 32'd0);
    check("rst_data_in", bus.DataMem_In, 32'd0);
    dataQ.push_back(32'h5); dataQ.push_back(32'h5);
    instQ.push_back(32'h24080001); instQ.push_back(32'h24080001);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      check("alt_ready", 32'({bus.InstMem_Ready, bus.DataMem_Ready}),
            (c % 4 == 1) ? 32'b01 : (c % 4 == 3) ? 32'b10 : 32'b00);
      check("alt_rd_en", 32'(bus.ramReadEnable), (c % 2 == 0) ? 32'd1 : 32'd0);
      if (c % 4 == 0) check("alt_addr_data", 32'(bus.ramReadAddr), 32'd3);
      if (c % 4 == 2) check("alt_addr_inst", 32'(bus.ramReadAddr), 32'd2);
      @(posedge clock); #1;
    end
    dropReq();
    check("alt_drained", 32'(instQ.size() + dataQ.size()), 32'd0);

    for (int i = 0; i < 14; i++) doAccess(vecs[i]);

    // Last grant was data: contention now grants instruction first.
    @(posedge clock); #1;
    bus.InstMem_Read = 1'b1; bus.InstMem_Address = 30'd2;
    bus.DataMem_Read = 1'b1; bus.DataMem_Address = 30'd3;
    instQ.push_back(32'h24080001); dataQ.push_back(32'h5);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      check("prio_ready", 32'({bus.InstMem_Ready, bus.DataMem_Ready}),
            (c == 1) ? 32'b10 : (c == 3) ? 32'b01 : 32'b00);
      if (c == 0) check("prio_addr_inst", 32'(bus.ramReadAddr), 32'd2);
      if (c == 2) check("prio_addr_data", 32'(bus.ramReadAddr), 32'd3);
      @(posedge clock); #1;
    end
    dropReq();
    check("prio_drained", 32'(instQ.size() + dataQ.size()), 32'd0);

    // Reset lands while a load is in RD_DATA: no Ready, outputs cleared at once.
    @(posedge clock); #1;
    bus.DataMem_Read = 1'b1; bus.DataMem_Address = 30'd5;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("midrst_ready", 32'({bus.InstMem_Ready, bus.DataMem_Ready}), 32'd0);
    check("midrst_ram_en", 32'({bus.ramReadEnable, bus.ramWriteEnable, bus.ramWriteLane}), 32'd0);
    check("midrst_data_in", bus.DataMem_In, 32'd0);
    @(posedge clock); #1;
    dropReq();
    reset = 1'b0;
    doAccess('{1'b0, 1'b1, 4'h0, 30'd5, 32'h0, 32'hDEADBEEF});

    repeat (2) @(posedge clock);
    check("final_drained", 32'(instQ.size() + dataQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mips32_ram_arbiter.md
# mips32_ram_arbiter

Bus-side controller that sits between the MIPS32 core's instruction and data memory ports and a single block RAM instance with one registered-address read port and one byte-laned write port. It arbitrates the two core requestors onto the RAM, sequences the RAM's one-cycle read latency, and returns a one-cycle `Ready` pulse per completed access. It is the initiator on the RAM's read/write port.

## Interface
- `AWIDTH`, 10, RAM word-address width; RAM depth is 2^AWIDTH 32-bit words.
- `clock` in 1, sole clock; all state changes on the rising edge.
- `reset` in 1, asynchronous, active-high; clears all state immediately.
- `InstMem_Read` in 1, instruction fetch request; held by the core until `InstMem_Ready`.
- `InstMem_Address` in 30, word address of the fetch.
- `InstMem_In` out 32, fetched word; valid only while `InstMem_Ready`=1.
- `InstMem_Ready` out 1, one-cycle completion pulse for a fetch.
- `DataMem_Read` in 1, data load request; held until `DataMem_Ready`.
- `DataMem_Write` in 4, byte-lane write enables; nonzero = store request; held until `DataMem_Ready`.
- `DataMem_Address` in 30, word address of the load/store.
- `DataMem_Out` in 32, store data from the core.
- `DataMem_In` out 32, load data; valid only while `DataMem_Ready`=1.
- `DataMem_Ready` out 1, one-cycle completion pulse for a load or store.
- `ramReadAddr` out AWIDTH, `ramReadEnable` out 1, `ramReadData` in 32: RAM read port; data valid the cycle after `ramReadEnable`.
- `ramWriteAddr` out AWIDTH, `ramWriteData` out 32, `ramWriteLane` out 4, `ramWriteEnable` out 1: RAM write port.

## Operation
- States: IDLE, RD_INST, RD_DATA, WR_DONE. Plus `lastData` flag (1 = last grant went to data port).
- Data request = `DataMem_Read | (|DataMem_Write)`. If both read and write are set, treated as a store.
- RAM index = address[AWIDTH-1:0]; upper address bits ignored (accesses alias/wrap, no error).
- IDLE, no request: all RAM enables 0, stay IDLE.
- IDLE, arbitration when both ports request: grant data if `lastData`=0, else grant instruction. Single requestor is granted directly.
- Grant instruction: `ramReadEnable`=1, `ramReadAddr`=inst index; next state RD_INST; `lastData`<=0.
- Grant data load: `ramReadEnable`=1, `ramReadAddr`=data index; next RD_DATA; `lastData`<=1.
- Grant data store: `ramWriteEnable`=1, `ramWriteLane`=`DataMem_Write`, `ramWriteAddr`=data index, `ramWriteData`=`DataMem_Out`; next WR_DONE; `lastData`<=1.
- RD_INST: `InstMem_Ready`=1, `InstMem_In`=`ramReadData`; next IDLE.
- RD_DATA: `DataMem_Ready`=1, `DataMem_In`=`ramReadData`; next IDLE.
- WR_DONE: `DataMem_Ready`=1, `DataMem_In`=0; next IDLE.
- No RAM enable is asserted outside IDLE, so the still-held request is never re-issued and a write never coincides with a read's data cycle (RAM write bypass never exercised by this block).
- RAM control outputs are combinational from state and requests; Ready outputs decode from the state register only.

## Timing
- Reset values: state IDLE, `lastData`=0, both Ready=0, `InstMem_In`/`DataMem_In`=0; all RAM enables and `ramWriteLane` forced 0 while `reset`=1.
- Latency: request seen in IDLE at cycle N -> Ready=1 in cycle N+1 for loads, fetches and stores; store lands in RAM at edge ending cycle N.
- Throughput: one access per 2 cycles; earliest next grant is cycle N+2.
- Both ports continuously requesting: grants alternate data, inst, data, inst... starting with data after reset.
- Request dropped by core before Ready: not supported; behaviour is completion regardless (Ready still pulses).
- Reset asserted mid-access: state returns to IDLE and Ready drops immediately; pending read discarded; a store issued before reset remains written.

## Test plan
- Store 0xDEADBEEF, lanes 4'b1111 at word 5, then load word 5 -> `DataMem_Ready` at N+1 for store; load returns 0xDEADBEEF one cycle after its grant.
- Byte-lane store 0x000000AA lanes 4'b0001 over 0x11223344 at word 7 -> subsequent load returns 0x112233AA.
- Fetch and load both held high from reset, inst word 2 = 0x24080001, data word 3 = 0x5 -> data Ready in cycle 1, inst Ready in cycle 3, correct data, pattern repeats alternating.
- Load at address 0x400+9 with AWIDTH=10 -> returns contents of word 9 (aliasing).
- Assert reset during RD_DATA -> `DataMem_Ready` never pulses, all outputs 0 same cycle, next request after release completes normally.
- Held fetch request across its Ready cycle -> `ramReadEnable` low in Ready cycle, exactly one RAM read per 2 cycles.
